// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths and state/grant encodings for the array_4 SRAM front-end
package sram_ctrl_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: circular read-response buffer whose depth need not be a power of two
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] slots [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dout  = slots[rd_ptr];
    assign empty = count == '0;

    // storage carries no reset; pointers and occupancy alone define validity
    always_ff @(posedge clock)
        if (push) slots[wr_ptr] <= din;

    // pointer and occupancy tracking
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end

    // the upstream credit check must make a push into a full buffer impossible
    assert property (@(posedge clock) disable iff (!reset_n) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/array_4_port_ctrl.sv
// array_4_port_ctrl: arbitrating front-end for the single-port, lane-masked array_4_ext SRAM macro
module array_4_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RESP_DEPTH = 3,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    state_t            state;
    grant_t            grant;
    logic [ADDR_W-1:0] cnt;
    logic [CW-1:0]     count;
    logic              inflight, rr_last_rd, rd_elig, filling, empty;

    // credit check on registered occupancy, then round-robin when both sides contend
    always_comb begin
        rd_elig = (32'(count) + 32'(inflight)) < 32'(RESP_DEPTH);
        grant   = GNT_NONE;
        if (state == S_RUN) begin
            if (wr_valid && rd_valid && rd_elig) grant = rr_last_rd ? GNT_WR : GNT_RD;
            else if (wr_valid) grant = GNT_WR;
            else if (rd_valid && rd_elig) grant = GNT_RD;
        end
    end

    // macro port drive: the zero-fill owns the port during init, otherwise the granted request
    always_comb begin
        filling   = state == S_INIT;
        wr_ready  = grant == GNT_WR;
        rd_ready  = grant == GNT_RD;
        mem_en    = filling | wr_ready | rd_ready;
        mem_wmode = filling | wr_ready;
        mem_addr  = filling ? cnt : wr_ready ? wr_addr : rd_ready ? rd_addr : '0;
        mem_wmask = filling ? '1 : wr_ready ? wr_mask : '0;
        mem_wdata = wr_ready ? wr_data : '0;
    end

    // sequencing FSM with fill counter, read-latency tracking and arbitration history
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            init_done  <= 1'b0;
            inflight   <= 1'b0;
            rr_last_rd <= 1'b0;
        end else begin
            inflight <= grant == GNT_RD;
            if (grant != GNT_NONE) rr_last_rd <= grant == GNT_RD;
            case (state)
                S_IDLE: begin
                    state     <= INIT_ZERO ? S_INIT : S_RUN;
                    init_done <= !INIT_ZERO;
                end
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end

    assign resp_valid = !empty;

    sram_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (inflight),
        .pop     (resp_valid && resp_ready),
        .din     (mem_rdata),
        .dout    (resp_data),
        .count   (count),
        .empty   (empty)
    );
endmodule

// File: tb/tb_array_4_port_ctrl.sv
// tb_array_4_port_ctrl: directed stimulus with a response scoreboard for array_4_port_ctrl
module tb_array_4_port_ctrl;
    logic       clock, reset_n;
    logic       wr_valid, wr_ready, rd_valid, rd_ready;
    logic [7:0] wr_addr, wr_data, rd_addr, resp_data;
    logic [3:0] wr_mask;
    logic       resp_valid, resp_ready, init_done;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_en, mem_wmode;
    logic [3:0] mem_wmask;

    int         compared, mism;
    logic [7:0] exp_q[$];
    logic [7:0] sram [256];

    array_4_port_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_wmode  (mem_wmode),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural macro: unreset garbage contents, 2-bit lane mask, registered read data
    initial for (int i = 0; i < 256; i++) sram[i] = 8'hA5 ^ 8'(i);
    always @(posedge clock)
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < 4; l++)
                    if (mem_wmask[l]) sram[mem_addr][2*l +: 2] <= mem_wdata[2*l +: 2];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // monitor: every accepted response is checked against the oldest expected entry
    always @(negedge clock)
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mism++;
                $display("FAIL resp_unexpected: got %0h expected no response", resp_data);
            end else begin
                chk("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
            end
        end

    // one clock of stimulus; an accepted read pushes its hand-computed expected data
    task automatic cycle(input logic wv, input logic [7:0] wa, input logic [7:0] wd, input logic [3:0] wm,
                         input logic rv, input logic [7:0] ra, input logic [7:0] rexp,
                         output logic gw, output logic gr, output logic rvs, output logic [7:0] rds);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = ra;
        @(negedge clock);
        gw  = wv && wr_ready;
        gr  = rv && rd_ready;
        rvs = resp_valid;
        rds = resp_data;
        chk("one_grant", 32'(wr_ready && rd_ready), 32'd0);
        if (gr) exp_q.push_back(rexp);
        @(posedge clock); #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    // counts edges from reset release until init_done, recording the first fill cycle
    task automatic wait_init(output int n, output logic any_rdy, output logic [7:0] first_addr, output logic first_ok);
        n = 0; any_rdy = 1'b0; first_addr = 8'hFF; first_ok = 1'b0;
        while (!init_done && n < 400) begin
            @(negedge clock);
            if (wr_ready || rd_ready) any_rdy = 1'b1;
            if (n == 1) begin
                first_addr = mem_addr;
                first_ok   = mem_en && mem_wmode && mem_wmask == 4'hF && mem_wdata == 8'h00;
            end
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic init_seq();
        int n;
        logic any_rdy, ok;
        logic [7:0] fa;
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'h33; rd_addr = 8'h44;
        wait_init(n, any_rdy, fa, ok);
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("init_cycles", 32'(n), 32'd257);
        chk("ready_during_init", 32'(any_rdy), 32'd0);
        chk("fill_first_addr", 32'(fa), 32'd0);
        chk("fill_first_drive", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic gw, gr, rvs;
        logic [7:0] rds, wd;
        logic [7:0] t1_addr [3] = '{8'h00, 8'h7F, 8'hFF};
        logic [7:0] t5_rexp [6] = '{8'h00, 8'h00, 8'h61, 8'h00, 8'h62, 8'h00};
        int k;
        compared = 0; mism = 0;
        reset_n = 1'b0; resp_ready = 1'b0;
        wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", 32'({wr_ready, rd_ready, resp_valid, init_done, mem_en, mem_wmode,
                                  mem_addr, mem_wmask, mem_wdata}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        init_seq();
        resp_ready = 1'b1;

        // zero-fill visible at the low, middle and top addresses
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'h00, 8'h00, 4'h0, 1, t1_addr[i], 8'h00, gw, gr, rvs, rds);
            chk("t1_rd_grant", 32'(gr), 32'd1);
        end
        drain();

        // lane-masked overwrite: FF with lanes 0 and 2 cleared gives CC
        cycle(1, 8'h10, 8'hFF, 4'hF, 0, 8'h00, 8'h00, gw, gr, rvs, rds);
        chk("t2_wr1_grant", 32'(gw), 32'd1);
        cycle(1, 8'h10, 8'h00, 4'b0101, 0, 8'h00, 8'h00, gw, gr, rvs, rds);
        chk("t2_wr2_grant", 32'(gw), 32'd1);
        cycle(0, 8'h00, 8'h00, 4'h0, 1, 8'h10, 8'hCC, gw, gr, rvs, rds);
        chk("t2_rd_grant", 32'(gr), 32'd1);
        drain();

        // back-to-back reads with a free consumer
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'h20 + 8'(i), 8'h30 + 8'(i), 4'hF, 0, 8'h00, 8'h00, gw, gr, rvs, rds);
            chk("t3_wr_grant", 32'(gw), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'h00, 8'h00, 4'h0, i < 6, 8'h20 + 8'(i), 8'h30 + 8'(i), gw, gr, rvs, rds);
            if (i < 6) chk("t3_rd_grant", 32'(gr), 32'd1);
            if (i >= 2) chk("t3_resp_valid", 32'(rvs), 32'd1);
        end
        drain();

        // stalled consumer: credits allow exactly three reads, writes keep flowing
        resp_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 8'h00, 8'h00, 4'h0, 1, 8'h20 + 8'(k), 8'h30 + 8'(k), gw, gr, rvs, rds);
            chk("t4_rd_grant", 32'(gr), 32'(i < 3));
            if (gr) k++;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h40 + 8'(i), 8'h70 + 8'(i), 4'hF, 1, 8'h23, 8'h33, gw, gr, rvs, rds);
            chk("t4_wr_grant", 32'(gw), 32'd1);
            chk("t4_rd_blocked", 32'(gr), 32'd0);
            chk("t4_head_hold", 32'({rvs, rds}), 32'h130);
        end
        resp_ready = 1'b1;
        drain();

        // contention: alternate RD, WR, ... on one address, reads see program order
        wd = 8'h61;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'h50, wd, 4'hF, 1, 8'h50, t5_rexp[i], gw, gr, rvs, rds);
            chk("t5_grant", 32'({gw, gr}), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (gw) wd++;
        end
        drain();

        // reset with two responses buffered and one read in flight
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'h00, 8'h00, 4'h0, 1, 8'h20 + 8'(i), 8'h30 + 8'(i), gw, gr, rvs, rds);
            chk("t6_rd_grant", 32'(gr), 32'd1);
        end
        chk("t6_buffered", 32'(resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_clears", 32'({resp_valid, init_done, mem_en}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        init_seq();
        resp_ready = 1'b1;
        cycle(0, 8'h00, 8'h00, 4'h0, 1, 8'h10, 8'h00, gw, gr, rvs, rds);
        chk("t6_rd_grant_after", 32'(gr), 32'd1);
        cycle(0, 8'h00, 8'h00, 4'h0, 1, 8'h50, 8'h00, gw, gr, rvs, rds);
        chk("t6_rd_grant_after", 32'(gr), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
